// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Owns the fetch PC, issues one-cycle-latency reads
// to a synchronous instruction ROM and hands {instr, pc} pairs to decode
// through a valid/ready handshake. A 2-entry buffer keeps one instruction per
// cycle flowing under backpressure; a jump redirects the PC and flushes both
// the buffer and any read still in flight.
//
// Ports
//   CLK          sole clock, all state changes on posedge
//   RST          synchronous active-high reset, overrides jump
//   jump_valid   redirect request
//   jump_addr    redirect target, zero-extended to PC_WIDTH
//   imem_en      ROM read strobe (combinational)
//   imem_addr    ROM read address, always the fetch PC
//   imem_rdata   ROM data, valid the cycle after imem_en
//   instr_valid  head buffer entry is valid
//   instr_ready  decode accepts the head entry
//   instr        head instruction
//   instr_pc     address the head instruction was fetched from
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int JADDR_WIDTH = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   jump_valid,
  input  logic [JADDR_WIDTH-1:0] jump_addr,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc
);

  logic [PC_WIDTH-1:0]    pc;
  logic                   inflight;
  logic [PC_WIDTH-1:0]    inflight_pc;
  logic [INSTR_WIDTH-1:0] buf_instr [2];
  logic [PC_WIDTH-1:0]    buf_pc    [2];
  logic                   head;
  logic [1:0]             count;

  logic       pop;
  logic       push;
  logic       issue;
  logic       tail;
  logic [2:0] occupancy;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;

  // Slots committed after this cycle: buffered entries plus the read in
  // flight, minus whatever decode takes now. Issuing only while this stays
  // below 2 guarantees the returning word always has a free slot.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !RST && !jump_valid && (occupancy < 3'd2);

  // Returning ROM data is dropped when a jump lands in the same cycle.
  assign push = inflight && !jump_valid;

  // With count==2 a push only happens alongside a pop, so writing into the
  // head slot that is being vacated is correct.
  assign tail = head ^ count[0];

  assign imem_en   = issue;
  assign imem_addr = pc;
  assign instr     = buf_instr[head];
  assign instr_pc  = buf_pc[head];

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (jump_valid) begin
      pc       <= PC_WIDTH'(jump_addr);
      inflight <= 1'b0;
      head     <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + PC_WIDTH'(1);
        inflight_pc <= pc;
      end
      if (push) begin
        buf_instr[tail] <= imem_rdata;
        buf_pc[tail]    <= inflight_pc;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A behavioural ROM answers reads one
// cycle after imem_en. The reference model is the architectural contract:
// after reset or a jump, decode sees consecutive PCs from the start address,
// each paired with ROM[pc]; fetch addresses are likewise consecutive; reads
// issued but not yet consumed never exceed two; a stalled head stays stable.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        jump_valid;
  logic [4:0]  jump_addr;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;

  logic [15:0] rom [256];

  int checks   = 0;
  int failures = 0;

  instr_fetch dut (
    .CLK         (CLK),
    .RST         (RST),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: data for the strobed address appears next cycle.
  always @(posedge CLK) begin
    if (imem_en) imem_rdata <= rom[imem_addr];
  end

  task automatic test_reset;
    RST = 1'b1; jump_valid = 1'b1; jump_addr = 5'h11; instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'(i * 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); #1;
    end
    checks++;
    if (imem_en !== 1'b0) begin failures++; $display("FAIL reset_imem_en got=%0b exp=0", imem_en); end
    checks++;
    if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_imem_addr got=%0h exp=0", imem_addr); end
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
    checks++;
    if (instr !== 16'h0 || instr_pc !== 8'h0) begin
      failures++; $display("FAIL reset_head got=%0h/%0h exp=0/0", instr, instr_pc);
    end
  endtask

  // Cycle 0 is the first cycle with reset released. Ready drops in 5..8.
  task automatic test_stream;
    logic [7:0] exp_pc = 8'h00;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      RST = 1'b0; jump_valid = 1'b0;
      instr_ready = !(c >= 5 && c <= 8);
      #1;
      if (c <= 4) begin
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 8'(c)) begin
          failures++; $display("FAIL stream_issue c=%0d got en=%0b addr=%0h exp en=1 addr=%0h", c, imem_en, imem_addr, c);
        end
      end else if (c >= 6 && c <= 8) begin
        checks++;
        if (imem_en !== 1'b0) begin failures++; $display("FAIL stall_no_issue c=%0d got=%0b exp=0", c, imem_en); end
      end
      if (c < 2) begin
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_latency c=%0d got=%0b exp=0", c, instr_valid); end
      end else begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          failures++;
          $display("FAIL stream_head c=%0d got v=%0b pc=%0h i=%0h exp v=1 pc=%0h i=%0h", c, instr_valid, instr_pc, instr, exp_pc, rom[exp_pc]);
        end
        if (instr_ready) exp_pc++;
      end
    end
  endtask

  task automatic test_jump;
    for (int j = 0; j < 7; j++) begin
      @(negedge CLK);
      jump_valid = (j == 0); jump_addr = 5'h1A; instr_ready = 1'b1;
      #1;
      if (j == 0) begin
        checks++;
        if (imem_en !== 1'b0) begin failures++; $display("FAIL jump_no_issue got=%0b exp=0", imem_en); end
      end else if (j == 1) begin
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 8'h1A) begin
          failures++; $display("FAIL jump_target_issue got en=%0b addr=%0h exp en=1 addr=1a", imem_en, imem_addr);
        end
      end
      if (j == 1 || j == 2) begin
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL jump_flush j=%0d got=%0b exp=0", j, instr_valid); end
      end else if (j >= 3) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'(8'h1A + j - 3) || instr !== rom[8'(8'h1A + j - 3)]) begin
          failures++;
          $display("FAIL jump_stream j=%0d got v=%0b pc=%0h i=%0h exp pc=%0h", j, instr_valid, instr_pc, instr, 8'h1A + j - 3);
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_pc = 8'h1F;
    logic       saw_wrap = 1'b0;
    for (int j = 0; j < 240; j++) begin
      @(negedge CLK);
      jump_valid = (j == 0); jump_addr = 5'h1F; instr_ready = 1'b1;
      #1;
      if (j >= 3) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          failures++;
          $display("FAIL wrap_stream j=%0d got v=%0b pc=%0h i=%0h exp pc=%0h i=%0h", j, instr_valid, instr_pc, instr, exp_pc, rom[exp_pc]);
        end
        if (exp_pc == 8'h00) saw_wrap = 1'b1;
        exp_pc++;
      end
    end
    checks++;
    if (saw_wrap !== 1'b1) begin failures++; $display("FAIL wrap_reached got=%0b exp=1", saw_wrap); end
  endtask

  task automatic test_reset_mid;
    for (int r = 0; r < 5; r++) begin
      @(negedge CLK);
      RST = (r == 0); jump_valid = (r == 0); jump_addr = 5'h0C; instr_ready = 1'b1;
      #1;
      if (r == 0) begin
        checks++;
        if (imem_en !== 1'b0) begin failures++; $display("FAIL rstmid_no_issue got=%0b exp=0", imem_en); end
      end else if (r == 1) begin
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 8'h0) begin
          failures++; $display("FAIL rstmid_outputs got v=%0b i=%0h pc=%0h exp 0/0/0", instr_valid, instr, instr_pc);
        end
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 8'h00) begin
          failures++; $display("FAIL rstmid_restart got en=%0b addr=%0h exp en=1 addr=0", imem_en, imem_addr);
        end
      end else if (r == 2) begin
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_latency got=%0b exp=0", instr_valid); end
      end else begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'(r - 3) || instr !== rom[8'(r - 3)]) begin
          failures++; $display("FAIL rstmid_stream r=%0d got v=%0b pc=%0h exp pc=%0h", r, instr_valid, instr_pc, r - 3);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0]  exp_del   = 8'h00;
    logic [7:0]  exp_fetch = 8'h00;
    int          outstanding = 0;
    int          idle = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  held_pc = 8'h00;
    logic [15:0] held_instr = 16'h0;
    RST = 1'b1; jump_valid = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    for (int c = 0; c < 2; c++) @(negedge CLK);
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      RST         = 1'b0;
      instr_ready = ($urandom_range(0, 3) != 0);
      jump_valid  = ($urandom_range(0, 39) == 0);
      jump_addr   = 5'($urandom);
      #1;
      if (hold_prev) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== held_pc || instr !== held_instr) begin
          failures++;
          $display("FAIL rand_stable c=%0d got v=%0b pc=%0h i=%0h exp pc=%0h i=%0h", c, instr_valid, instr_pc, instr, held_pc, held_instr);
        end
      end
      if (jump_valid) begin
        checks++;
        if (imem_en !== 1'b0) begin failures++; $display("FAIL rand_jump_issue c=%0d got=%0b exp=0", c, imem_en); end
      end else if (imem_en === 1'b1) begin
        checks++;
        if (imem_addr !== exp_fetch) begin
          failures++; $display("FAIL rand_fetch_addr c=%0d got=%0h exp=%0h", c, imem_addr, exp_fetch);
        end
        exp_fetch++;
        outstanding++;
      end
      if (instr_valid === 1'b1 && instr_ready) begin
        checks++;
        if (instr_pc !== exp_del || instr !== rom[exp_del]) begin
          failures++;
          $display("FAIL rand_deliver c=%0d got pc=%0h i=%0h exp pc=%0h i=%0h", c, instr_pc, instr, exp_del, rom[exp_del]);
        end
        exp_del++;
        outstanding--;
      end
      if (jump_valid) begin
        exp_del     = {3'b000, jump_addr};
        exp_fetch   = {3'b000, jump_addr};
        outstanding = 0;
        idle        = 0;
      end else begin
        idle = (instr_valid === 1'b1) ? 0 : idle + 1;
        checks++;
        if (outstanding > 2 || outstanding < 0) begin
          failures++; $display("FAIL rand_occupancy c=%0d got=%0d exp=0..2", c, outstanding);
        end
        checks++;
        if (idle > 2) begin
          failures++; $display("FAIL rand_bubble c=%0d got idle=%0d exp<=2", c, idle);
        end
      end
      hold_prev  = (instr_valid === 1'b1) && !instr_ready && !jump_valid;
      held_pc    = instr_pc;
      held_instr = instr;
    end
  endtask

  initial begin
    RST = 1'b1; jump_valid = 1'b0; jump_addr = 5'h0; instr_ready = 1'b0;
    test_reset;
    test_stream;
    test_jump;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
